// File: rtl/ifetch_unit_if.sv
// Instruction-memory channel between the fetch unit (master) and instruction memory (slave):
// valid/ready request carrying a word address, plus an in-order response with no back-pressure.
interface ifetch_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        rsp_valid;
   logic [31:0] rsp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: sequential word fetches, in-order response buffer, redirect flush.
// Optional macro IFETCH_MISALIGN_CHK_EN enables the sticky misaligned-redirect fault.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_BOOT  | first cycle after reset, no fetch issued
// ST_RUN   | normal issue; responses pushed into the buffer
// ST_DRAIN | after a redirect, waiting for stale in-flight responses
module ifetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   ifetch_unit_if.master imem,
   input  logic          redirect_valid_i,
   input  logic [31:0]   redirect_pc_i,
   output logic          if_valid_o,
   input  logic          if_ready_i,
   output logic [31:0]   if_inst_o,
   output logic [31:0]   if_pc_o,
   output logic          if_fault_o
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      ST_BOOT,
      ST_RUN,
      ST_DRAIN
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   rsp_pc_q, rsp_pc_d;
   logic [CW-1:0] outst_q, outst_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]   pc_mem_q   [FIFO_DEPTH];
   logic [31:0]   inst_mem_q [FIFO_DEPTH];

   logic [CW:0]   occ;
   logic [31:0]   redir_tgt;
   logic          fetch_block;
   logic          req_valid;
   logic          req_fire;
   logic          push;
   logic          pop;

   assign redir_tgt = redirect_pc_i & 32'hFFFF_FFFC;

`ifdef IFETCH_MISALIGN_CHK_EN
   logic fault_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (redirect_valid_i) begin
         fault_q <= |redirect_pc_i[1:0];
      end
   end

   assign fetch_block = fault_q;
`else
   assign fetch_block = 1'b0;
`endif

   assign if_fault_o = fetch_block;

   // Buffered entries count against the in-flight budget so a response always has a slot.
   assign occ = {1'b0, outst_q} + {1'b0, count_q};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      drop_d     = drop_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;

      req_valid = (state_q == ST_RUN) && !fetch_block && (occ < (CW+1)'(FIFO_DEPTH));
      req_fire  = req_valid && imem.req_ready;
      push      = imem.rsp_valid && (drop_q == '0) && !redirect_valid_i;
      pop       = (count_q != '0) && if_ready_i && !redirect_valid_i;

      outst_d = outst_q + CW'(req_fire) - CW'(imem.rsp_valid);
      count_d = count_q + CW'(push) - CW'(pop);

      if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (push) begin
         rsp_pc_d = rsp_pc_q + 32'd4;
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      if (imem.rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);

      case (state_q)
         ST_BOOT:  state_d = ST_RUN;
         ST_DRAIN: if (drop_d == '0) state_d = ST_RUN;
         default:  state_d = state_q;
      endcase

      // Everything still in flight after this edge belongs to the old stream.
      if (redirect_valid_i) begin
         fetch_pc_d = redir_tgt;
         rsp_pc_d   = redir_tgt;
         drop_d     = outst_d;
         count_d    = '0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         state_d    = (outst_d != '0) ? ST_DRAIN : ST_RUN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BOOT;
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            pc_mem_q[i]   <= RESET_PC;
            inst_mem_q[i] <= 32'h0;
         end
      end else if (push) begin
         pc_mem_q[wr_ptr_q]   <= rsp_pc_q;
         inst_mem_q[wr_ptr_q] <= imem.rsp_data;
      end
   end

   assign imem.req_valid = req_valid;
   assign imem.req_addr  = fetch_pc_q;
   assign if_valid_o     = (count_q != '0);
   assign if_pc_o        = pc_mem_q[rd_ptr_q];
   assign if_inst_o      = inst_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_ifetch_unit.sv
// Randomized bench for ifetch_unit: a memory model with variable latency plus a stream-level
// reference (expected output queue, expected next fetch address, stale-response epochs).
`timescale 1ns/1ps
module tb_ifetch_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          DEPTH    = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_fault;

   always #5 clk = ~clk;

   ifetch_unit_if imem ();

   ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .imem             (imem),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .if_valid_o       (if_valid),
      .if_ready_i       (if_ready),
      .if_inst_o        (if_inst),
      .if_pc_o          (if_pc),
      .if_fault_o       (if_fault)
   );

   typedef struct { logic [31:0] addr; int due; int epoch; } mreq_t;
   typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

   mreq_t       mem_q[$];
   ent_t        exp_q[$];
   logic [31:0] exp_addr;
   int          epoch = 0;
   int          cyc = 0;
   bit          fault_m = 1'b0;
   int          pr_ready = 100, pr_ifr = 100, pr_redir = 0;
   int          lat_min = 1, lat_max = 1;
   bit          force_redir = 1'b0, redir_on_rsp = 1'b0;
   logic [31:0] force_tgt = 32'h0;
   int          n_checks = 0, n_pass = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a ^ 32'h5A5A_C3C3) + {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask

   task automatic one_cycle();
      bit          redir, rsp, ifr, rdy, exp_v;
      int          stale, had;
      logic [31:0] tgt;
      mreq_t       e;
      ent_t        x;
      @(negedge clk);
      stale = 0;
      foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale++;
      exp_v = !fault_m && (stale == 0) && (mem_q.size() + exp_q.size() < DEPTH);
      chk("req_valid", 32'(imem.req_valid), 32'(exp_v));
      if (imem.req_valid) chk("req_addr", imem.req_addr, exp_addr);
      chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0 && if_valid) begin
         chk("if_pc", if_pc, exp_q[0].pc);
         chk("if_inst", if_inst, exp_q[0].inst);
      end
      chk("if_fault", 32'(if_fault), 32'(fault_m));

      rdy = ($urandom_range(99) < pr_ready);
      ifr = ($urandom_range(99) < pr_ifr);
      rsp = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
      redir = (force_redir && (!redir_on_rsp || rsp)) || ($urandom_range(99) < pr_redir);
      tgt = $urandom_range(32'h0000_FFFF);
      if ($urandom_range(9) != 0) tgt[1:0] = 2'b00;
      if (force_redir && redir) begin
         tgt = force_tgt;
         force_redir = 1'b0;
      end

      imem.req_ready = rdy;
      if_ready       = ifr;
      redirect_valid = redir;
      redirect_pc    = tgt;
      imem.rsp_valid = rsp;
      imem.rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;

      had = exp_q.size();
      if (rsp) begin
         e = mem_q.pop_front();
         if (e.epoch == epoch && !redir) begin
            x.pc = e.addr;
            x.inst = mem_word(e.addr);
            exp_q.push_back(x);
         end
      end
      if (had != 0 && ifr && !redir) void'(exp_q.pop_front());
      if (imem.req_valid && rdy) begin
         e.addr = imem.req_addr;
         e.due = cyc + 1 + int'($urandom_range(lat_max - 1, lat_min - 1));
         e.epoch = epoch;
         mem_q.push_back(e);
         exp_addr = exp_addr + 32'd4;
      end
      if (redir) begin
         epoch++;
         exp_q.delete();
         exp_addr = tgt & 32'hFFFF_FFFC;
`ifdef IFETCH_MISALIGN_CHK_EN
         fault_m = (tgt[1:0] != 2'b00);
`endif
      end
      cyc++;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) one_cycle();
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      imem.rsp_valid = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem.req_valid), 32'(0));
      chk("rst_req_addr", imem.req_addr, RESET_PC);
      chk("rst_if_valid", 32'(if_valid), 32'(0));
      chk("rst_if_inst", if_inst, 32'h0);
      chk("rst_if_pc", if_pc, RESET_PC);
      chk("rst_if_fault", 32'(if_fault), 32'(0));
      mem_q.delete();
      exp_q.delete();
      exp_addr = RESET_PC;
      fault_m = 1'b0;
      epoch++;
      repeat (hold) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int guard;
      imem.req_ready = 1'b0;
      imem.rsp_valid = 1'b0;
      imem.rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      if_ready       = 1'b0;
      do_reset(3);

      run(30);

      pr_ifr = 0;
      run(10);
      chk("stall_no_req", 32'(imem.req_valid), 32'(0));
      chk("stall_full", 32'(if_valid), 32'(1));
      pr_ifr = 100;
      run(10);

      pr_ready = 0;
      run(5);
      pr_ready = 100;
      run(10);

      lat_min = 3; lat_max = 3;
      guard = 0;
      while (mem_q.size() != 2 && guard < 50) begin one_cycle(); guard++; end
      chk("two_inflight", 32'(mem_q.size()), 32'(2));
      force_redir = 1'b1; force_tgt = 32'h100;
      one_cycle();
      guard = 0;
      while (!if_valid && guard < 30) begin one_cycle(); guard++; end
      chk("redir_first_pc", if_pc, 32'h100);
      run(10);

      force_redir = 1'b1; redir_on_rsp = 1'b1; force_tgt = 32'h200;
      run(20);
      force_redir = 1'b0; redir_on_rsp = 1'b0;
      lat_min = 1; lat_max = 1;
      run(10);

      force_redir = 1'b1; force_tgt = 32'hFFFF_FFF8;
      run(20);

      force_redir = 1'b1; force_tgt = 32'h102;
      run(10);
`ifdef IFETCH_MISALIGN_CHK_EN
      chk("fault_set", 32'(if_fault), 32'(1));
      chk("fault_no_req", 32'(imem.req_valid), 32'(0));
`endif
      force_redir = 1'b1; force_tgt = 32'h200;
      run(10);
      chk("fault_clear", 32'(if_fault), 32'(0));

      lat_min = 1; lat_max = 4;
      pr_ready = 70; pr_ifr = 60; pr_redir = 3;
      run(1500);
      do_reset(2);
      run(1500);
      pr_redir = 0; pr_ready = 100; pr_ifr = 100;
      run(20);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
